// File: rtl/intctl_multi.sv
// intctl_multi: arbitrates NCHAN interrupt sources onto one Unibus BR/BG level
// and runs the BR -> SACK -> BBSY/INTR -> SSYN vector transfer for the winner.
module intctl_multi #(
    parameter int NCHAN  = 4,
    parameter int GDLY   = 4,
    parameter int ROTATE = 0,
    parameter int TMO    = 1023
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [8*NCHAN-1:0] intvecs,
    input  logic               bbsy_in_h,
    input  logic               bg_in_l,
    input  logic               init_in_h,
    input  logic               sack_in_h,
    input  logic               ssyn_in_h,
    output logic               bbsy_out_h,
    output logic               bg_out_l,
    output logic               br_out_h,
    output logic [15:0]        d_out_h,
    output logic               intr_out_h,
    output logic               sack_out_h,
    output logic [NCHAN-1:0]   intack,
    output logic               inttmo
);

    localparam int SELW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_SACK, S_MASTER} state_t;

    state_t            state_q;
    logic              br_q, sack_q, bbsy_q, intr_q, inttmo_q;
    logic [15:0]       d_q;
    logic [NCHAN-1:0]  intack_q;
    logic [3:0]        dly_q;
    logic [15:0]       tmo_q;
    logic [SELW-1:0]   sel_q, ptr_q;
    logic [SELW-1:0]   sel_d;
    logic [NCHAN-1:0]  req;
    logic              any;
    logic [7:0]        selvec;

    // SACK from other masters is visible on the port but drives no decision
    logic unused_sack;
    assign unused_sack = sack_in_h;

    // Per-channel request: bit0 low means the channel holds a vector
    for (genvar i = 0; i < NCHAN; i++) begin : g_req
        assign req[i] = ~intvecs[8*i];
    end
    assign any    = |req;
    assign selvec = intvecs[int'(sel_q)*8 +: 8];

    // Winner: lowest index, or first requester after the last serviced one
    always_comb begin
        int   idx;
        logic found;
        sel_d = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NCHAN; k++) begin
            idx = (ROTATE != 0) ? ((int'(ptr_q) + 1 + k) % NCHAN) : k;
            if (!found && req[idx]) begin
                found = 1'b1;
                sel_d = SELW'(idx);
            end
        end
    end

    // Bus request / grant / vector transfer sequencer with registered outputs
    always_ff @(posedge CLOCK) begin
        if (!RESET || init_in_h) begin
            state_q  <= S_IDLE;
            br_q     <= 1'b0;
            sack_q   <= 1'b0;
            bbsy_q   <= 1'b0;
            intr_q   <= 1'b0;
            d_q      <= '0;
            intack_q <= '0;
            inttmo_q <= 1'b0;
            dly_q    <= '0;
            tmo_q    <= '0;
            sel_q    <= '0;
            ptr_q    <= '0;
        end else begin
            intack_q <= '0;
            inttmo_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A grant already low here belongs to a downstream device
                    if (any && bg_in_l) begin
                        br_q    <= 1'b1;
                        dly_q   <= '0;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bg_in_l) begin
                        dly_q <= '0;
                    end else if (dly_q != 4'(GDLY)) begin
                        dly_q <= dly_q + 4'd1;
                    end else begin
                        br_q    <= 1'b0;
                        sack_q  <= 1'b1;
                        sel_q   <= sel_d;
                        state_q <= S_SACK;
                    end
                end
                S_SACK: begin
                    if (!bbsy_in_h && bg_in_l && !ssyn_in_h) begin
                        sack_q <= 1'b0;
                        if (!intvecs[int'(sel_q)*8]) begin
                            bbsy_q  <= 1'b1;
                            intr_q  <= 1'b1;
                            d_q     <= {8'b0, selvec[7:2], 2'b00};
                            tmo_q   <= '0;
                            state_q <= S_MASTER;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_MASTER: begin
                    if (ssyn_in_h) begin
                        bbsy_q          <= 1'b0;
                        intr_q          <= 1'b0;
                        d_q             <= '0;
                        intack_q[sel_q] <= 1'b1;
                        ptr_q           <= sel_q;
                        state_q         <= S_IDLE;
                    end else if (tmo_q == 16'(TMO)) begin
                        bbsy_q   <= 1'b0;
                        intr_q   <= 1'b0;
                        d_q      <= '0;
                        inttmo_q <= 1'b1;
                        state_q  <= S_IDLE;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign br_out_h   = br_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;
    assign intr_out_h = intr_q;
    assign d_out_h    = d_q;
    assign intack     = intack_q;
    assign inttmo     = inttmo_q;
    assign bg_out_l   = br_q | bg_in_l;

endmodule

// File: tb/tb_intctl_multi.sv
// Bench for intctl_multi: a fixed-priority instance (TMO=8) and a round-robin
// instance share one bus; a transaction-level model predicts each winner.
module tb_intctl_multi;

    localparam int GDLY = 4;

    logic        CLOCK = 1'b0;
    logic        RESET, bbsy_in_h, bg_in_l, init_in_h, sack_in_h, ssyn_in_h;
    logic [31:0] intvecs;
    logic        bbsyA, bgoA, brA, intrA, sackA, tmoA;
    logic        bbsyB, bgoB, brB, intrB, sackB, tmoB;
    logic [15:0] dA, dB;
    logic [3:0]  ackA, ackB;

    logic [7:0]  vec [4];
    int          ptrB;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 CLOCK = ~CLOCK;

    intctl_multi #(.NCHAN(4), .GDLY(GDLY), .ROTATE(0), .TMO(8)) u_fix (
        .CLOCK(CLOCK), .RESET(RESET), .intvecs(intvecs), .bbsy_in_h(bbsy_in_h),
        .bg_in_l(bg_in_l), .init_in_h(init_in_h), .sack_in_h(sack_in_h),
        .ssyn_in_h(ssyn_in_h), .bbsy_out_h(bbsyA), .bg_out_l(bgoA), .br_out_h(brA),
        .d_out_h(dA), .intr_out_h(intrA), .sack_out_h(sackA), .intack(ackA),
        .inttmo(tmoA));

    intctl_multi #(.NCHAN(4), .GDLY(GDLY), .ROTATE(1), .TMO(1023)) u_rr (
        .CLOCK(CLOCK), .RESET(RESET), .intvecs(intvecs), .bbsy_in_h(bbsy_in_h),
        .bg_in_l(bg_in_l), .init_in_h(init_in_h), .sack_in_h(sack_in_h),
        .ssyn_in_h(ssyn_in_h), .bbsy_out_h(bbsyB), .bg_out_l(bgoB), .br_out_h(brB),
        .d_out_h(dB), .intr_out_h(intrB), .sack_out_h(sackB), .intack(ackB),
        .inttmo(tmoB));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic apply();
        intvecs = {vec[3], vec[2], vec[1], vec[0]};
    endtask

    function automatic logic [3:0] req_mask();
        logic [3:0] m;
        for (int i = 0; i < 4; i++) m[i] = ~vec[i][0];
        return m;
    endfunction

    function automatic int win_fixed(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return 0;
    endfunction

    function automatic int win_rr(input logic [3:0] m, input int p);
        for (int k = 1; k <= 4; k++) if (m[(p + k) % 4]) return (p + k) % 4;
        return 0;
    endfunction

    function automatic logic [15:0] bus_word(input logic [7:0] v);
        return 16'(v) & 16'h00FC;
    endfunction

    task automatic clear_vecs();
        for (int i = 0; i < 4; i++) vec[i] = 8'($urandom) | 8'h01;
    endtask

    // One transaction; ssyn_wait < 0 means SSYN never comes
    task automatic run_txn(input bit pre_bg_low, input int glitch, input bit hold_extra,
                           input bit bbsy_delay, input bit withdraw, input int ssyn_wait,
                           input bit keep_req);
        int wa, wb, n;
        logic [3:0]  m;
        logic [15:0] expA, expB;
        m  = req_mask();
        wa = win_fixed(m);
        wb = win_rr(m, ptrB);
        if (pre_bg_low) begin
            bg_in_l = 1'b0;
            apply();
            repeat (3) begin
                step();
                check_eq("idle_bg_low_br", brA, 1'b0);
                check_eq("idle_bg_low_bgo", bgoA, 1'b0);
            end
            bg_in_l = 1'b1;
        end else begin
            apply();
        end
        step();
        check_eq("br_assert_A", brA, 1'b1);
        check_eq("br_assert_B", brB, 1'b1);
        if (glitch > 0) begin
            bg_in_l = 1'b0;
            repeat (glitch) begin
                step();
                check_eq("glitch_no_sack", sackA, 1'b0);
            end
            bg_in_l = 1'b1;
            step();
        end
        bg_in_l = 1'b0;
        #1 check_eq("req_bgo_high", bgoA, 1'b1);
        n = 0;
        do begin
            step();
            n++;
        end while (!sackA && n < 40);
        check_eq("sack_delay", n, GDLY + 1);
        check_eq("sack_br_drop", brA, 1'b0);
        check_eq("sack_B", sackB, 1'b1);
        check_eq("sack_bgo_low", bgoA, 1'b0);
        if (hold_extra) begin
            step();
            check_eq("sack_hold_bg", sackA, 1'b1);
        end
        bg_in_l = 1'b1;
        if (bbsy_delay) begin
            bbsy_in_h = 1'b1;
            step();
            check_eq("sack_hold_bbsy", sackA, 1'b1);
            bbsy_in_h = 1'b0;
        end
        if (withdraw) begin
            vec[wa][0] = 1'b1;
            apply();
        end
        expA = bus_word(vec[wa]);
        expB = bus_word(vec[wb]);
        step();
        check_eq("sack_drop", sackA, 1'b0);
        if (withdraw) begin
            check_eq("wd_bbsy", bbsyA, 1'b0);
            check_eq("wd_intr", intrA, 1'b0);
            step();
            check_eq("wd_ackA", ackA, 4'b0);
            check_eq("wd_ackB", ackB, 4'b0);
            check_eq("wd_br", brA, 1'b0);
            return;
        end
        check_eq("master_bbsy", bbsyA, 1'b1);
        check_eq("master_intr", intrA, 1'b1);
        check_eq("master_dA", dA, expA);
        check_eq("master_dB", dB, expB);
        for (int i = 0; i < 4; i++) vec[i][7:2] = 6'($urandom);
        apply();
        if (ssyn_wait < 0) begin
            repeat (8) begin
                step();
                check_eq("tmo_intr_high", intrA, 1'b1);
            end
            step();
            check_eq("tmo_intr_low", intrA, 1'b0);
            check_eq("tmo_pulse", tmoA, 1'b1);
            check_eq("tmo_bbsy", bbsyA, 1'b0);
            check_eq("tmo_d", dA, 16'h0);
            check_eq("tmo_no_ack", ackA, 4'b0);
            check_eq("tmo_B_still", intrB, 1'b1);
            step();
            check_eq("tmo_pulse_end", tmoA, 1'b0);
            RESET = 1'b0;
            clear_vecs();
            apply();
            step();
            check_eq("rst_intrB", intrB, 1'b0);
            check_eq("rst_bbsyB", bbsyB, 1'b0);
            check_eq("rst_dB", dB, 16'h0);
            check_eq("rst_ackB", ackB, 4'b0);
            check_eq("rst_tmoB", tmoB, 1'b0);
            RESET = 1'b1;
            ptrB = 0;
            step();
            return;
        end
        repeat (ssyn_wait) begin
            step();
            check_eq("d_stable", dA, expA);
            check_eq("intr_held", intrA, 1'b1);
        end
        ssyn_in_h = 1'b1;
        step();
        check_eq("ssyn_intr", intrA, 1'b0);
        check_eq("ssyn_bbsy", bbsyA, 1'b0);
        check_eq("ssyn_d", dA, 16'h0);
        check_eq("ackA", ackA, 4'b1 << wa);
        check_eq("ackB", ackB, 4'b1 << wb);
        check_eq("ssyn_no_tmo", tmoA, 1'b0);
        ptrB = wb;
        ssyn_in_h = 1'b0;
        if (!keep_req) clear_vecs();
        apply();
        step();
        check_eq("ackA_end", ackA, 4'b0);
        check_eq("ackB_end", ackB, 4'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b0; bbsy_in_h = 1'b0; bg_in_l = 1'b1; init_in_h = 1'b0;
        sack_in_h = 1'b0; ssyn_in_h = 1'b0; ptrB = 0;
        clear_vecs();
        apply();
        repeat (3) step();
        check_eq("rst_br", brA, 1'b0);
        check_eq("rst_sack", sackA, 1'b0);
        check_eq("rst_bbsy", bbsyA, 1'b0);
        check_eq("rst_intr", intrA, 1'b0);
        check_eq("rst_d", dA, 16'h0);
        check_eq("rst_ack", ackA, 4'b0);
        check_eq("rst_bgo_high", bgoA, 1'b1);
        bg_in_l = 1'b0;
        #1 check_eq("rst_bgo_low", bgoA, 1'b0);
        bg_in_l = 1'b1;
        RESET = 1'b1;
        step();

        // ch1 (0o070) beats ch2 (0o060) under fixed priority
        clear_vecs();
        vec[2] = 8'o060;
        vec[1] = 8'o070;
        run_txn(0, 0, 1, 0, 0, 2, 0);

        // ch3 alone, then ch0 and ch3 held over four transactions
        clear_vecs();
        vec[3] = 8'o124;
        run_txn(0, 0, 0, 0, 0, 1, 0);
        clear_vecs();
        vec[0] = 8'o200;
        vec[3] = 8'o314;
        for (int t = 0; t < 4; t++) run_txn(0, 0, 0, 0, 0, 1, (t < 3));

        // grant glitch restarts the deglitch count
        clear_vecs();
        vec[2] = 8'o240;
        run_txn(0, 3, 0, 1, 0, 0, 0);

        // grant already low in IDLE is passed downstream
        clear_vecs();
        vec[0] = 8'o100;
        run_txn(1, 0, 0, 0, 0, 1, 0);

        // withdrawal during SACK
        clear_vecs();
        vec[2] = 8'o330;
        run_txn(0, 0, 0, 0, 1, 0, 0);

        // INIT while requesting aborts the request
        clear_vecs();
        vec[1] = 8'o150;
        apply();
        step();
        check_eq("init_pre_br", brA, 1'b1);
        init_in_h = 1'b1;
        clear_vecs();
        apply();
        step();
        check_eq("init_br", brA, 1'b0);
        init_in_h = 1'b0;
        ptrB = 0;
        step();

        // SSYN timeout, then RESET mid-MASTER on the round-robin instance
        clear_vecs();
        vec[1] = 8'o374;
        run_txn(0, 0, 0, 0, 0, -1, 0);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            logic [3:0] m;
            bit single;
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++)
                vec[i] = m[i] ? (8'($urandom) & 8'hFE) : (8'($urandom) | 8'h01);
            single = ($countones(m) == 1);
            run_txn(1'($urandom_range(0, 3) == 0), $urandom_range(0, 1) * $urandom_range(1, GDLY),
                    1'($urandom), 1'($urandom), single && ($urandom_range(0, 3) == 0),
                    $urandom_range(0, 6), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intctl_multi.md
Name: intctl_multi

Overview:
- Multi-channel successor to the single-requester interrupt bus-request block.
- Arbitrates NCHAN local interrupt sources onto one Unibus BR/BG level and runs the BR -> SACK -> BBSY/INTR -> SSYN vector-transfer sequence for the winning channel.
- Adds fixed or round-robin channel priority, a parametrised grant deglitch, per-channel acknowledge pulses, and an SSYN timeout.
- Sits between device register blocks and the bus interface.

Parameters:
NCHAN, 4, number of interrupt sources (1..16)
GDLY, 4, consecutive cycles BG must be seen low before the grant is accepted (1..15)
ROTATE, 0, 0 = fixed priority (channel 0 highest); 1 = round-robin starting after the last serviced channel
TMO, 1023, cycles to wait for SSYN after INTR before aborting (1..65535)

Ports:
CLOCK  in  1  system clock; all logic on posedge
RESET  in  1  synchronous, active-low reset
intvecs  in  8*NCHAN  per-channel vector; channel i = bits [8i+7:8i]; bit0=1 means no request, else vector (bits[1:0] of vector ignored)
bbsy_in_h  in  1  bus busy
bg_in_l  in  1  bus grant in, active low
init_in_h  in  1  bus INIT
sack_in_h  in  1  selection acknowledge (any master)
ssyn_in_h  in  1  slave sync
bbsy_out_h  out  1  drive BBSY
bg_out_l  out  1  grant passed downstream = br_out_h | bg_in_l
br_out_h  out  1  bus request
d_out_h  out  16  data lines; {8'b0, vec[7:2], 2'b00} during INTR, else 0
intr_out_h  out  1  drive INTR
sack_out_h  out  1  drive SACK
intack  out  NCHAN  one-cycle pulse on the channel whose vector SSYN accepted
inttmo  out  1  one-cycle pulse on SSYN timeout

Behaviour:
- RESET low or init_in_h high (sampled at the edge): state=IDLE; all outputs 0 except bg_out_l, which follows its equation; dly, tmo counter, sel and the rotation pointer cleared. Takes effect mid-transfer with no acknowledge or timeout pulse.
- any = OR over channels of ~intvecs[8i].
- IDLE: if any & bg_in_l, then br_out_h<=1, dly<=0, go REQ. A low bg_in_l in IDLE belongs downstream and is never stolen.
- REQ (br_out_h=1):
  - bg_in_l=1: dly<=0.
  - bg_in_l=0 and dly!=GDLY: dly<=dly+1.
  - bg_in_l=0 and dly==GDLY: br_out_h<=0, sack_out_h<=1, latch sel = winning requester, go SACK.
  - Minimum BG-low to SACK is GDLY+1 cycles.
  - If all requests withdraw while in REQ, stay in REQ; the grant is still taken and then released in SACK.
- Winner selection:
  - ROTATE=0: lowest requesting index.
  - ROTATE=1: first requesting index scanning upward from ptr+1 mod NCHAN; ptr <= sel when intack pulses.
  - If none request at latch time, sel=0 (handled as withdrawn).
- SACK: wait for ~bbsy_in_h & bg_in_l & ~ssyn_in_h, then sack_out_h<=0.
  - If intvecs[8*sel] is 0 at that cycle: bbsy_out_h<=1, intr_out_h<=1, d_out_h<={8'b0, intvecs[8*sel+7:8*sel+2], 2'b00}, tmo<=0, go MASTER.
  - Otherwise (withdrawn) go IDLE with no pulses.
- MASTER:
  - ssyn_in_h=1: drop bbsy_out_h, intr_out_h and d_out_h to 0; intack[sel] pulses 1 cycle; go IDLE.
  - Else tmo increments; at tmo==TMO: drop the same outputs, inttmo pulses 1 cycle, go IDLE.
  - ptr is not updated on timeout.
- Re-request only from IDLE, so there is at least one idle cycle between transactions.
- Vector changes after latch are ignored; d_out_h is constant throughout MASTER.
- sack_in_h is observed only for bench visibility; no state decision depends on it.

Test Plan:
- NCHAN=4, ROTATE=0: ch2 vec 0o060, ch1 vec 0o070 both active; BG low 6 cycles -> SACK after GDLY+1=5 BG-low cycles; d_out_h=0o070; SSYN -> intack=4'b0010 for one cycle, bus outputs to 0 the same edge.
- ROTATE=1, ch0 and ch3 held active over 4 transactions -> serviced order 0,3,0,3.
- BG low for 3 cycles, high 1, then low 5 -> dly restarts; SACK only after the 5th continuous low cycle.
- BG already low in IDLE when ch0 requests -> br_out_h stays 0 and bg_out_l stays low until BG rises; then br asserts.
- Channel withdraws (bit0->1) during SACK -> SACK drops, no BBSY/INTR, no intack, back to IDLE.
- TMO=8, no SSYN -> INTR high 9 cycles, inttmo pulses, all outputs 0. Separately, RESET low mid-MASTER -> all outputs 0 next edge, no pulses.
